// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: one elastic pipeline boundary (payload + exc code + delay-slot flag).
// Two-entry skid buffer: M drives the outputs, S catches the beat that arrives while
// downstream stalls. in_ready depends only on registered state (!S.valid).
// Optional macro PIPE_STATS_EN adds saturating stall_cnt / flush_cnt outputs.
module pipe_stage_skid #(
    parameter int DATA_W = 64,
    parameter int EXC_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    input  logic              flush,
    input  logic              kill,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    output logic [1:0]        occupancy
`ifdef PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [EXC_W-1:0]  exc;
        logic              bd;
    } beat_t;

    beat_t m_q, m_d, s_q, s_d;
    logic  m_vld_q, m_vld_d, s_vld_q, s_vld_d;
    beat_t in_beat;
    logic  acc, deq;

    assign in_beat   = '{data: in_data, exc: in_exc, bd: in_bd};
    assign in_ready  = !s_vld_q;
    assign acc       = in_valid && in_ready;
    assign out_valid = m_vld_q;
    assign deq       = m_vld_q && out_ready;

    // Entries are zeroed whenever invalid, so a bubble reads as an all-zero NOP.
    assign out_data  = m_q.data;
    assign out_exc   = m_q.exc;
    assign out_bd    = m_q.bd;
    assign occupancy = {1'b0, m_vld_q} + {1'b0, s_vld_q};

    // Next-state: flush > kill > normal EMPTY/ONE/FULL transitions.
    always_comb begin
        m_vld_d = m_vld_q;
        m_d     = m_q;
        s_vld_d = s_vld_q;
        s_d     = s_q;
        if (flush) begin
            m_vld_d = 1'b0;
            m_d     = '0;
            s_vld_d = 1'b0;
            s_d     = '0;
        end else if (kill) begin
            // Younger beats die; M survives only if it was not just consumed.
            s_vld_d = 1'b0;
            s_d     = '0;
            if (deq) begin
                m_vld_d = 1'b0;
                m_d     = '0;
            end
        end else if (!m_vld_q) begin
            if (acc) begin
                m_vld_d = 1'b1;
                m_d     = in_beat;
            end
        end else if (!s_vld_q) begin
            if (acc && deq) begin
                m_d = in_beat;
            end else if (acc) begin
                s_vld_d = 1'b1;
                s_d     = in_beat;
            end else if (deq) begin
                m_vld_d = 1'b0;
                m_d     = '0;
            end
        end else if (deq) begin
            // FULL: promote the skid entry; no accept possible here.
            m_d     = s_q;
            s_vld_d = 1'b0;
            s_d     = '0;
        end
    end

    // State registers; synchronous reset clears both entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_vld_q <= 1'b0;
            m_q     <= '0;
            s_vld_q <= 1'b0;
            s_q     <= '0;
        end else begin
            m_vld_q <= m_vld_d;
            m_q     <= m_d;
            s_vld_q <= s_vld_d;
            s_q     <= s_d;
        end
    end

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Saturating event counters: downstream stall cycles and flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (m_vld_q && !out_ready && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed + random checks of pipe_stage_skid against a
// depth-2 FIFO reference queue (head = M, second = S).
module tb_pipe_stage_skid;
    localparam int DATA_W = 64;
    localparam int EXC_W  = 5;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, in_bd, flush, kill;
    logic              out_valid, out_ready, out_bd;
    logic [DATA_W-1:0] in_data, out_data;
    logic [EXC_W-1:0]  in_exc, out_exc;
    logic [1:0]        occupancy;
`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
`endif

    pipe_stage_skid #(.DATA_W(DATA_W), .EXC_W(EXC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_exc(in_exc), .in_bd(in_bd), .flush(flush), .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_exc(out_exc), .out_bd(out_bd), .occupancy(occupancy)
`ifdef PIPE_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [EXC_W-1:0]  e;
        logic              b;
    } beat_t;

    beat_t q[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [EXC_W-1:0] e,
                         input logic b, input logic ordy, input logic fl, input logic kl);
        in_valid = v; in_data = d; in_exc = e; in_bd = b;
        out_ready = ordy; flush = fl; kill = kl;
    endtask

    // Compare DUT state at the falling edge, then advance the model and one clock.
    task automatic cyc();
        logic acc, deq;
        beat_t nb;
        @(negedge clk);
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data", out_data,       q[0].d);
            chk("out_exc",  64'(out_exc),   64'(q[0].e));
            chk("out_bd",   64'(out_bd),    64'(q[0].b));
        end else begin
            chk("bubble_data", out_data,     64'd0);
            chk("bubble_exc",  64'(out_exc), 64'd0);
            chk("bubble_bd",   64'(out_bd),  64'd0);
        end
        acc = in_valid && (q.size() < 2);
        deq = (q.size() > 0) && out_ready;
        nb  = '{d: in_data, e: in_exc, b: in_bd};
        if (rst || flush) begin
            q.delete();
        end else if (kill) begin
            if (q.size() == 2) q.delete(1);
            if (deq) void'(q.pop_front());
        end else begin
            if (deq) void'(q.pop_front());
            if (acc) q.push_back(nb);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 64'd9, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();                                    // reset state

        // Streaming 1..4 with downstream always ready
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 64'(i), 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc();
        end
        drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); cyc();

        // Back-pressure: A,B stack up, then drain
        drive(1'b1, 64'hA, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b1, 64'hB, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b1, 64'hEE, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();   // refused: FULL
        drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); cyc(); cyc();

        // Flush from FULL while C is presented
        drive(1'b1, 64'hA, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b1, 64'hB, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b1, 64'hC, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); cyc();
        drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); cyc(); cyc();

        // Kill in ONE: without and with dequeue
        drive(1'b1, 64'hA, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b1, 64'hB, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
        drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b1, 64'hC, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1); cyc();
        drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();

        // Kill in FULL without dequeue: S dropped, M kept
        drive(1'b1, 64'h11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b1, 64'h22, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
        drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); cyc(); cyc();

        // Exception code and delay-slot flag ride with the payload
        drive(1'b1, 64'h1234_5678_9ABC_DEF0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0); cyc();
        drive(1'b1, 64'h55, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); cyc();
        drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); cyc(); cyc();

        // rst and flush together: everything reads zero afterwards
        drive(1'b1, 64'h77, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b1, 64'h88, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();

        // Random traffic with occasional kill/flush
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 5'($urandom),
                  1'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 19) == 0));
            cyc();
        end
        drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); cyc(); cyc();

`ifdef PIPE_STATS_EN
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("stall_cnt_rst0", 64'(stall_cnt), 64'd0);
        chk("flush_cnt_rst0", 64'(flush_cnt), 64'd0);
        drive(1'b1, 64'hA, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc();
        drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0); cyc(); cyc();
        drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("stall_cnt", 64'(stall_cnt), 64'd7);
        chk("flush_cnt", 64'(flush_cnt), 64'd2);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("stall_cnt_rst", 64'(stall_cnt), 64'd0);
        chk("flush_cnt_rst", 64'(flush_cnt), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
